// File: rtl/req_ack_done_responder.sv
// Responder side of a req/ack/done handshake: acks a req rise after ACK_DLY cycles,
// launches one backend command, and reports done with a success/error status.
module req_ack_done_responder #(
   parameter int ACK_DLY  = 2,
   parameter int MAX_DONE = 100,
   parameter int CMD_W    = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req,
   input  logic [CMD_W-1:0] cmd,
   output logic             ack,
   output logic             done,
   output logic             status_reg,
   output logic             busy,
   output logic             work_start,
   output logic [CMD_W-1:0] work_cmd,
   input  logic             work_rdy,
   input  logic             work_err
);

   localparam int CNT_MAX = (MAX_DONE > ACK_DLY) ? MAX_DONE : ACK_DLY;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ACK_WAIT,
      S_ACK,
      S_WORK,
      S_DONE
   } state_t;

   state_t             state_q;
   logic [CNT_W-1:0]   cnt_q;
   logic               req_q;
   logic               ack_q;
   logic               done_q;
   logic               status_q;
   logic               busy_q;
   logic               work_start_q;
   logic [CMD_W-1:0]   work_cmd_q;
   logic               rise;

   assign rise = req & ~req_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         req_q        <= 1'b1;
         ack_q        <= 1'b0;
         done_q       <= 1'b0;
         status_q     <= 1'b0;
         busy_q       <= 1'b0;
         work_start_q <= 1'b0;
         work_cmd_q   <= '0;
      end else begin
         req_q        <= req;
         ack_q        <= 1'b0;
         work_start_q <= 1'b0;
         done_q       <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (rise) begin
                  work_cmd_q <= cmd;
                  busy_q     <= 1'b1;
                  cnt_q      <= CNT_W'(1);
                  // With a one-cycle delay the ack is due in the very next cycle.
                  if (ACK_DLY == 1) begin
                     state_q      <= S_ACK;
                     ack_q        <= 1'b1;
                     work_start_q <= 1'b1;
                  end else begin
                     state_q <= S_ACK_WAIT;
                  end
               end
            end
            S_ACK_WAIT: begin
               if (cnt_q == CNT_W'(ACK_DLY - 1)) begin
                  state_q      <= S_ACK;
                  ack_q        <= 1'b1;
                  work_start_q <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            S_ACK: begin
               state_q <= S_WORK;
               cnt_q   <= CNT_W'(1);
            end
            S_WORK: begin
               // The last WORK cycle is reserved for the timeout; work_rdy there is ignored.
               if (cnt_q == CNT_W'(MAX_DONE - 1)) begin
                  state_q  <= S_DONE;
                  done_q   <= 1'b1;
                  status_q <= 1'b1;
               end else if (work_rdy) begin
                  state_q  <= S_DONE;
                  done_q   <= 1'b1;
                  status_q <= work_err;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            S_DONE: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign ack        = ack_q;
   assign done       = done_q;
   assign status_reg = status_q;
   assign busy       = busy_q;
   assign work_start = work_start_q;
   assign work_cmd   = work_cmd_q;

endmodule
